// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned DEFAULT_MAX_BURST = 8;

  typedef enum logic {
    REQ_CORE   = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick with a loader lock override; one-hot grant out.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    prio,
  input  logic       locked,
  output logic [1:0] gnt
);

  // Lock wins while the loader is asking; otherwise the pointer breaks ties.
  always_comb begin
    gnt = 2'b00;
    if (locked && req[1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = (prio == REQ_LOADER) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the core (0) and the loader (1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned HI_LSB = ADDR_W + 2;

  mem_req_t         req0_s, req1_s, sel;
  logic [1:0]       req_v, gnt;
  logic             oor;
  req_id_t          prio_q, prio_d, resp_sel_q, resp_sel_d;
  logic             locked_q, locked_d;
  logic             rd_q, rd_d, err_q, err_d, oor_q, oor_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, burst_nxt;

  assign req0_s = '{we: we0, addr: addr0, wdata: wdata0};
  assign req1_s = '{we: we1, addr: addr1, wdata: wdata1};

  // No grants are issued while reset is held.
  assign req_v = {req1 & ~RESET, req0 & ~RESET};

  rr_pick2 u_pick (
    .req    (req_v),
    .prio   (prio_q),
    .locked (locked_q),
    .gnt    (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign sel  = gnt[1] ? req1_s : req0_s;
  assign oor  = (sel.addr >> HI_LSB) != 32'd0;

  // Drive the RAM from the granted request; out-of-range grants never touch it.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt) begin
      mem_en    = ~oor;
      mem_we    = sel.we & ~oor;
      mem_addr  = sel.addr[ADDR_W+1:2];
      mem_wdata = sel.wdata;
    end
  end

  // Pointer, burst lock and response-routing next state.
  always_comb begin
    prio_d      = prio_q;
    locked_d    = locked_q;
    burst_cnt_d = burst_cnt_q;
    resp_sel_d  = resp_sel_q;
    rd_d        = 1'b0;
    err_d       = 1'b0;
    oor_d       = 1'b0;
    burst_nxt   = burst_cnt_q + CNT_W'(1);
    if (|gnt) begin
      resp_sel_d = gnt[1] ? REQ_LOADER : REQ_CORE;
      prio_d     = gnt[1] ? REQ_CORE : REQ_LOADER;
      rd_d       = ~sel.we;
      err_d      = oor;
      oor_d      = oor;
    end
    if (gnt[1]) begin
      if (lock1 && (burst_nxt < CNT_W'(MAX_BURST))) begin
        locked_d    = 1'b1;
        burst_cnt_d = burst_nxt;
      end else begin
        locked_d    = 1'b0;
        burst_cnt_d = '0;
      end
    end
    if (!req1) begin
      locked_d    = 1'b0;
      burst_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prio_q      <= REQ_CORE;
      locked_q    <= 1'b0;
      burst_cnt_q <= '0;
      resp_sel_q  <= REQ_CORE;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      locked_q    <= locked_d;
      burst_cnt_q <= burst_cnt_d;
      resp_sel_q  <= resp_sel_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      oor_q       <= oor_d;
    end
  end

  // Route the RAM read data back to the requester granted last cycle.
  assign rvalid0 = rd_q & (resp_sel_q == REQ_CORE) & ~RESET;
  assign rvalid1 = rd_q & (resp_sel_q == REQ_LOADER) & ~RESET;
  assign err0    = err_q & (resp_sel_q == REQ_CORE) & ~RESET;
  assign err1    = err_q & (resp_sel_q == REQ_LOADER) & ~RESET;
  assign rdata0  = (rvalid0 & ~oor_q) ? mem_rdata : '0;
  assign rdata1  = (rvalid1 & ~oor_q) ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port synchronous data RAM (DMEM) between the RV32I core data port (requester 0) and the test/DMA loader (requester 1). Each cycle it grants at most one request, drives the RAM, and returns read data one cycle later on the granted requester's response channel. Round-robin priority, plus an optional bounded burst lock for the loader, keeps the core stall time bounded.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth = 2**ADDR_W words)
- MAX_BURST, 8, maximum consecutive locked grants to requester 1

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address; bits [1:0] ignored, bits [ADDR_W+1:2] select the word
- wdata0 / wdata1  in  32  write data
- lock1  in  1  requester 1 asks to keep the grant on the next cycle
- gnt0 / gnt1  out  1  combinational grant, same cycle as the accepted request
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a read grant
- rdata0 / rdata1  out  32  read data, qualified by rvalid
- err0 / err1  out  1  registered, one cycle after a grant whose addr bits [31:ADDR_W+2] are non-zero
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- At most one of gnt0/gnt1 is high in any cycle. gnt is asserted only when the corresponding req is high.
- Priority pointer `prio` (reset 0 = requester 0 first):
  - Only one req high: grant it.
  - Both high: grant `prio`, unless lock is active (see below).
  - After any grant, `prio` becomes the other requester.
- Lock:
  - A grant to requester 1 with lock1=1 sets `locked`, and `burst_cnt` counts the grants.
  - While `locked` and req1 is high, requester 1 is granted even if req0 is high.
  - When `burst_cnt` reaches MAX_BURST, or lock1=0 on a grant, or req1 is low: clear `locked` and reset `burst_cnt`.
  - After a forced release, requester 0 wins the next cycle if req0 is high.
- Out-of-range address:
  - The request is still granted, but mem_en stays 0, so no RAM access occurs.
  - err pulses next cycle. For a read, rvalid also pulses with rdata = 0.
- Granted cycle drives the RAM: mem_en=1 (for an in-range address), mem_we=we, mem_addr=addr[ADDR_W+1:2], mem_wdata=wdata.
- No grant: mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care but held at 0.
- The read response is routed by a registered `resp_sel` and a registered read flag. rdata of the non-selected requester is 0.
- Writes produce no rvalid.

## Timing
- Grant latency: 0 cycles, combinational from req/prio/locked.
- Read latency: rvalid/rdata exactly 1 cycle after the granted cycle.
- Back-to-back grants every cycle are legal. A response and a new grant may coincide.
- Worst-case core wait with req1 continuously high: MAX_BURST cycles.
- Reset values:
  - gnt0 = gnt1 = 0 while RESET is high.
  - rvalid0/1 = 0, err0/1 = 0, rdata0/1 = 0.
  - mem_en = mem_we = 0.
  - prio = 0, locked = 0, burst_cnt = 0.
- Reset mid-operation: a pending read response is dropped (no rvalid on the cycle after RESET), and no lock survives reset.
- A requester that deasserts req before gnt is not granted. This is legal and has no side effects.

## Structure
- Package `dmem_arb_pkg`:
  - typedef `req_id_t` (enum REQ_CORE=0, REQ_LOADER=1)
  - struct `mem_req_t` {we, addr, wdata}
  - constant DEFAULT_MAX_BURST
- Sub-module `rr_pick2`: combinational two-way round-robin pick from req[1:0], prio and locked. It returns a one-hot grant. All registers stay in `dmem_arbiter`.
- burst_cnt width: $clog2(MAX_BURST+1).

## Test plan
- Reset: hold RESET 2 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_en=0, rvalid=0. First cycle after reset -> gnt0=1.
- Contention, no lock: req0 and req1 both held for 4 cycles, both reads -> grants alternate 0,1,0,1. Each rvalid follows its grant by exactly 1 cycle with the preloaded RAM word.
- Write then read: requester 1 writes 0xDEADBEEF to addr 0x10, then requester 0 reads 0x10 -> rdata0=0xDEADBEEF, rvalid0 one cycle after gnt0, rvalid1 never high.
- Burst lock, MAX_BURST=8: req1=lock1=1 continuously, req0=1 -> exactly 8 consecutive gnt1, then gnt0, then requester 1 resumes.
- Out of range, ADDR_W=10: requester 0 reads addr 0x0000_1000 -> gnt0=1, mem_en=0, next cycle err0=1, rvalid0=1, rdata0=0.
- Reset mid-read: RESET asserted in the cycle after a read grant -> rvalid stays 0, and prio/locked return to 0.
